// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to transmitter and
// receiver) and the default clock / line-rate constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD_RATE  = 9600;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: the serial pin plus the byte-level outputs.
// The master is the receiver; the slave is the pin driver / byte consumer.
interface uart_rx_if;

  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_error,
    output rx_busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags the
// high-to-low transition that may mark a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_m;
  logic rx_d;

  // Two synchronizer stages followed by a one-cycle history register.
  // NOTE: all three reset to the idle-high line level so leaving reset on an
  // idle line never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what makes this a shift chain.
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled start detection and mid-bit sampling.
// Emits a one-cycle rx_valid for a good frame or frame_error for a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int DIV_W  = $clog2(DIV + 1);
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST       = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(OVERSAMPLE - 1);

  uart_state_e       state, state_nxt;
  logic              rx_s, fall;
  logic              tick;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic [7:0]        rx_data;
  logic              rx_valid, frame_error;

  // Control strobes produced by the next-state logic.
  logic tick_clr, shift_en, valid_nxt, ferr_nxt;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (bus.rx),
    .rx_s    (rx_s),
    .fall    (fall)
  );

  assign tick = (div_cnt == DIV_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and control decode; ticks are counted from 1 after start detect.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_nxt = state;
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        if (tick && tick_cnt == TICK_HALF_LAST) begin
          if (!rx_s) begin
            state_nxt = DATA;
            tick_clr  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && tick_cnt == TICK_LAST) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick && tick_cnt == TICK_LAST) begin
          state_nxt = IDLE;
          if (rx_s) valid_nxt = 1'b1;
          else      ferr_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and shift register; held clear in IDLE so the start-detect cycle
  // leaves div_cnt, tick_cnt and bit_cnt at zero and ticks align to the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick_clr)  tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + TICK_W'(1);
      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

  // Registered byte output and the two mutually exclusive strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= valid_nxt;
      frame_error <= ferr_nxt;
      if (valid_nxt) rx_data <= shift_reg;
    end
  end

  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.frame_error = frame_error;
  assign bus.rx_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=1 (16-clock bits, 10-unit clock period).
// A negedge monitor logs strobes; each test task checks against hand values.
module tb_uart_rx;

  localparam int BIT_T = 160;  // 16 clocks of period 10

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  uart_rx_if bus ();

  uart_rx #(
    .CLOCK_FREQ (16_000),
    .BAUD_RATE  (1000),
    .OVERSAMPLE (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int         valid_cnt   = 0;
  int         ferr_cnt    = 0;
  int         overlap_cnt = 0;
  int         long_cnt    = 0;
  logic [7:0] data_log[$];
  time        valid_time  = 0;
  logic       prev_v      = 1'b0;
  logic       prev_f      = 1'b0;

  // Strobe monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cnt++;
      data_log.push_back(bus.rx_data);
      valid_time = $time;
    end
    if (bus.frame_error) ferr_cnt++;
    if (bus.rx_valid && bus.frame_error) overlap_cnt++;
    if ((bus.rx_valid && prev_v) || (bus.frame_error && prev_f)) long_cnt++;
    prev_v = bus.rx_valid;
    prev_f = bus.frame_error;
  end

  // Drives one frame starting now (call at a negedge); the line is left at
  // the stop-bit level when the stop period ends.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bit_t);
    bus.rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      #(bit_t);
    end
    bus.rx = stop_bit;
    #(bit_t);
  endtask

  task automatic test_reset;
    bus.rx  = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", bus.frame_error); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy got=%b exp=0", bus.rx_busy); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%b exp=0", bus.rx_busy); end
    checks++; if (valid_cnt + ferr_cnt !== 0) begin failures++; $display("FAIL idle_after_reset strobes got=%0d exp=0", valid_cnt + ferr_cnt); end
  endtask

  task automatic test_single;
    int  v0, f0;
    time t0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    t0 = $time;
    send_byte(8'hA5, 1'b1, BIT_T);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL single_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data_log.size() <= v0 || data_log[v0] !== 8'hA5) begin failures++; $display("FAIL single_strobe_data got=%h exp=a5", (data_log.size() > v0) ? data_log[v0] : 8'hxx); end
    checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("FAIL single_rx_data_hold got=%h exp=a5", bus.rx_data); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL single_no_frame_error got=%0d exp=%0d", ferr_cnt, f0); end
    // Strobe registered on the 155th rising edge after the pin fell (E+153).
    checks++; if (valid_time - t0 !== 64'd1550) begin failures++; $display("FAIL single_latency got=%0t exp=1550", valid_time - t0); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", bus.rx_busy); end
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h00, 1'b1, BIT_T);
    send_byte(8'hFF, 1'b1, BIT_T);
    send_byte(8'h55, 1'b1, BIT_T);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", valid_cnt - v0); end
    if (data_log.size() >= v0 + 3) begin
      checks++; if (data_log[v0] !== 8'h00) begin failures++; $display("FAIL b2b_byte0 got=%h exp=00", data_log[v0]); end
      checks++; if (data_log[v0+1] !== 8'hFF) begin failures++; $display("FAIL b2b_byte1 got=%h exp=ff", data_log[v0+1]); end
      checks++; if (data_log[v0+2] !== 8'h55) begin failures++; $display("FAIL b2b_byte2 got=%h exp=55", data_log[v0+2]); end
    end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL b2b_no_frame_error got=%0d exp=%0d", ferr_cnt, f0); end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, BIT_T);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=%0d", valid_cnt, v0); end
    checks++; if (bus.rx_data !== 8'h55) begin failures++; $display("FAIL ferr_data_kept got=%h exp=55", bus.rx_data); end
    repeat (40) @(negedge clk);
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL held_low_busy got=%b exp=0", bus.rx_busy); end
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (valid_cnt !== v0 || ferr_cnt - f0 !== 1) begin failures++; $display("FAIL held_low_no_strobe valid=%0d ferr=%0d exp valid=%0d ferr=%0d", valid_cnt, ferr_cnt - f0, v0, 1); end
  endtask

  task automatic test_false_start;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx = 1'b1;
    checks++; if (bus.rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_during got=%b exp=1", bus.rx_busy); end
    // Tick 8 is acted on at the 11th rising edge after the pin fell.
    repeat (6) @(negedge clk);
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_by_tick8 got=%b exp=0", bus.rx_busy); end
    repeat (200) @(negedge clk);
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=%0d", valid_cnt, v0); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL glitch_no_frame_error got=%0d exp=%0d", ferr_cnt, f0); end
  endtask

  task automatic test_reset_mid_frame;
    int         v0, f0;
    logic [7:0] d;
    d  = 8'hC3;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      bus.rx = d[i];
      #(BIT_T);
    end
    bus.rx = d[4];
    #(BIT_T / 2);
    checks++; if (bus.rx_busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b exp=1", bus.rx_busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL midreset_rx_data got=%h exp=00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0 || bus.frame_error !== 1'b0) begin failures++; $display("FAIL midreset_strobes got=%b%b exp=00", bus.rx_valid, bus.frame_error); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.rx_busy); end
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin failures++; $display("FAIL midreset_no_strobe valid=%0d ferr=%0d exp %0d %0d", valid_cnt, ferr_cnt, v0, f0); end
    send_byte(8'h81, 1'b1, BIT_T);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL after_reset_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (bus.rx_data !== 8'h81) begin failures++; $display("FAIL after_reset_data got=%h exp=81", bus.rx_data); end
  endtask

  task automatic test_skew;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h96, 1'b1, 155);  // 15.5-clock bits
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL skew_fast_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (bus.rx_data !== 8'h96) begin failures++; $display("FAIL skew_fast_data got=%h exp=96", bus.rx_data); end
    send_byte(8'h96, 1'b1, 165);  // 16.5-clock bits
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL skew_slow_count got=%0d exp=2", valid_cnt - v0); end
    checks++; if (data_log.size() < v0 + 2 || data_log[v0+1] !== 8'h96) begin failures++; $display("FAIL skew_slow_data got=%h exp=96", bus.rx_data); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL skew_no_frame_error got=%0d exp=%0d", ferr_cnt, f0); end
  endtask

  task automatic test_strobe_rules;
    checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", overlap_cnt); end
    checks++; if (long_cnt !== 0) begin failures++; $display("FAIL strobe_single_cycle got=%0d exp=0", long_cnt); end
  endtask

  initial begin
    bus.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_false_start();
    test_reset_mid_frame();
    test_skew();
    test_strobe_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
